capture_ctrl: RTL

//  Consumer end of the trigger handshake. Drives armed into the trigger block and takes back its

---
 rtl/capture_pkg.sv | 14 +
 rtl/capture_addr_ctr.sv | 43 ++++
 rtl/capture_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and defaults for the capture sequencer
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        TRIG  = 3'd3,
        DONE  = 3'd4
    } cap_state_t;

    localparam int CAP_DEPTH_DEF = 512;

endpackage

// File: rtl/capture_addr_ctr.sv
// rtl/capture_addr_ctr.sv - wrapping RAM write address counter with last-address snapshot
module capture_addr_ctr #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          snap_i,
    output logic [AW-1:0] addr_o,
    output logic [AW-1:0] last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_q;

    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (inc_i) begin
            addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        end
    end

    // snap_i captures the address being written this cycle, before the increment lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            last_q <= '0;
        end else begin
            addr_q <= addr_d;
            if (snap_i) begin
                last_q <= addr_q;
            end
        end
    end

    assign addr_o = addr_q;
    assign last_o = last_q;

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture sequencer: pre-trigger fill, arm, post-trigger count, done handshake
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DEPTH = CAP_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_capture_i,
    input  logic          sample_strobe_i,
    input  logic [AW-1:0] trig_pos_i,
    input  logic          trigger_i,
    input  logic          capture_done_clr_i,
    output logic          armed_o,
    output logic          set_capture_done_o,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [AW-1:0] trace_end_o,
    output logic          capture_done_o,
    output logic          busy_o
);

    cap_state_t    state_q;
    logic [AW-1:0] tp_q;
    logic [AW-1:0] pre_cnt_q;
    logic [AW-1:0] post_cnt_q;
    logic          armed_q;
    logic          set_done_q;
    logic          done_q;
    logic          busy_q;

    logic [AW-1:0] tp_clamped;
    logic [AW-1:0] pre_target;
    logic [AW-1:0] pre_next;
    logic [AW-1:0] post_next;
    logic          start;
    logic          wr;
    logic          last_wr;

    // trig_pos is AW bits wide, so only the lower clamp bound needs handling
    assign tp_clamped = (trig_pos_i == '0) ? AW'(1) : trig_pos_i;
    assign pre_target = AW'(DEPTH - 1) - tp_q + AW'(1);
    assign pre_next   = pre_cnt_q + AW'(1);
    assign post_next  = post_cnt_q + AW'(1);

    assign start   = (state_q == IDLE) && en_capture_i;
    assign wr      = sample_strobe_i && (state_q inside {FILL, ARMED, TRIG});
    assign last_wr = wr && (state_q == TRIG) && (post_next == tp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tp_q       <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            armed_q    <= 1'b0;
            set_done_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            set_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en_capture_i) begin
                        state_q    <= FILL;
                        tp_q       <= tp_clamped;
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                FILL: begin
                    if (wr) begin
                        pre_cnt_q <= pre_next;
                        if (pre_next == pre_target) begin
                            state_q <= ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (trigger_i) begin
                        state_q <= TRIG;
                    end
                end
                TRIG: begin
                    if (wr) begin
                        post_cnt_q <= post_next;
                        if (post_next == tp_q) begin
                            state_q    <= DONE;
                            set_done_q <= 1'b1;
                            done_q     <= 1'b1;
                            armed_q    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (capture_done_clr_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    capture_addr_ctr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start),
        .inc_i  (wr),
        .snap_i (last_wr),
        .addr_o (waddr_o),
        .last_o (trace_end_o)
    );

    assign we_o               = wr;
    assign armed_o            = armed_q;
    assign set_capture_done_o = set_done_q;
    assign capture_done_o     = done_q;
    assign busy_o             = busy_q;

endmodule
